// File: rtl/mac_result_combiner_acc_if.sv
// Handshake/data bundle between the multiplier, the result combiner and the
// accumulated-result consumer.
//   master : upstream/downstream side (drives beats and out_ready)
//   slave  : the combiner (drives in_ready, out_valid, acc_out, out_mode)
// Signals:
//   in_valid/in_ready      input beat handshake
//   result_0/result_1      even/odd slice partial sums from the multiplier
//   result_SIMD_carry      per-lane bit 16 of the SIMD lane sums
//   mode                   0 = 16x16, 1 = sum-of-8x8 SIMD
//   a_sign/b_sign          operand signedness
//   cfg_len                beats per accumulation group (0 acts as 1)
//   out_valid/out_ready    result handshake
//   acc_out/out_mode       accumulated result and the mode it was built in
interface mac_result_combiner_acc_if #(
    parameter int ACC_W = 48,
    parameter int LEN_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      result_0;
    logic [31:0]      result_1;
    logic [1:0]       result_SIMD_carry;
    logic             mode;
    logic             a_sign;
    logic             b_sign;
    logic [LEN_W-1:0] cfg_len;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_mode;

    modport master (
        output in_valid, result_0, result_1, result_SIMD_carry,
               mode, a_sign, b_sign, cfg_len, out_ready,
        input  in_ready, out_valid, acc_out, out_mode
    );

    modport slave (
        input  in_valid, result_0, result_1, result_SIMD_carry,
               mode, a_sign, b_sign, cfg_len, out_ready,
        output in_ready, out_valid, acc_out, out_mode
    );
endinterface

// File: rtl/mac_result_combiner_acc.sv
// Resolves the split partial sums of the precision-configurable multiplier
// into final products (one 32-bit product, or two 17-bit SIMD lane sums) and
// accumulates a configurable number of them per group.
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    mac_result_combiner_acc_if slave (beat in, accumulated result out)
// Pipeline: stage 1 registers the combined product, stage 2 is the
// accumulator. out_valid rises two cycles after the last beat is accepted.
module mac_result_combiner_acc #(
    parameter int ACC_W  = 48,
    parameter int LANE_W = 24,
    parameter int LEN_W  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    mac_result_combiner_acc_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, OUT} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               mode_q, mode_d;
    logic               sgn_q, sgn_d;
    logic               s1_vld_q, s1_vld_d;
    logic               s1_first_q, s1_first_d;
    logic               s1_last_q, s1_last_d;
    logic [ACC_W-1:0]   s1_val_q, s1_val_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               out_valid_q, out_valid_d;

    logic               in_ready;
    logic               accept;
    logic               first;
    logic               cur_mode;
    logic               cur_sgn;
    logic               last;
    logic [LEN_W-1:0]   len_in;
    logic [LEN_W-1:0]   cnt_inc;
    logic [31:0]        p_full;
    logic [15:0]        sum0, sum1;
    logic [16:0]        s0, s1;
    logic [ACC_W-1:0]   comb_val;
    logic [ACC_W-1:0]   lane_sum;

    assign in_ready = (state_q == IDLE) || (state_q == ACCUM);
    assign accept   = bus.in_valid && in_ready;
    assign first    = (state_q == IDLE);

    // Group configuration comes straight from the bus on the first beat and
    // from the latched copy afterwards.
    assign cur_mode = first ? bus.mode : mode_q;
    assign cur_sgn  = first ? (bus.a_sign | bus.b_sign) : sgn_q;
    assign len_in   = (bus.cfg_len == '0) ? LEN_W'(1) : bus.cfg_len;
    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign last     = first ? (len_in == LEN_W'(1)) : (cnt_inc == len_q);

    // Combine partial sums. Lane sums take bit 16 from the multiplier's
    // carry outputs since result_0/1 only hold the low 16 bits per lane.
    always_comb begin
        p_full   = bus.result_0 + bus.result_1;
        sum0     = bus.result_0[15:0]  + bus.result_1[15:0];
        sum1     = bus.result_0[31:16] + bus.result_1[31:16];
        s0       = {bus.result_SIMD_carry[0], sum0};
        s1       = {bus.result_SIMD_carry[1], sum1};
        comb_val = '0;
        if (cur_mode) begin
            comb_val[2*LANE_W-1:0] = {{(LANE_W-17){s1[16] & cur_sgn}}, s1,
                                      {(LANE_W-17){s0[16] & cur_sgn}}, s0};
        end else begin
            comb_val = {{(ACC_W-32){p_full[31] & cur_sgn}}, p_full};
        end
    end

    // Per-lane add keeps the lane carry from crossing into the upper lane.
    always_comb begin
        lane_sum = '0;
        lane_sum[LANE_W-1:0]        = acc_q[LANE_W-1:0] + s1_val_q[LANE_W-1:0];
        lane_sum[2*LANE_W-1:LANE_W] = acc_q[2*LANE_W-1:LANE_W]
                                    + s1_val_q[2*LANE_W-1:LANE_W];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        mode_d      = mode_q;
        sgn_d       = sgn_q;
        out_valid_d = out_valid_q;
        acc_d       = acc_q;
        s1_vld_d    = accept;
        s1_first_d  = accept && first;
        s1_last_d   = accept && last;
        s1_val_d    = accept ? comb_val : s1_val_q;

        if (s1_vld_q) begin
            if (s1_first_q)  acc_d = s1_val_q;
            else if (mode_q) acc_d = lane_sum;
            else             acc_d = acc_q + s1_val_q;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = LEN_W'(1);
                    len_d   = len_in;
                    mode_d  = bus.mode;
                    sgn_d   = bus.a_sign | bus.b_sign;
                    state_d = last ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Final beat is entering the accumulator this edge.
                if (s1_vld_q && s1_last_q) begin
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            mode_q      <= 1'b0;
            sgn_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_val_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            sgn_q       <= sgn_d;
            s1_vld_q    <= s1_vld_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_val_q    <= s1_val_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_q;
    assign bus.out_mode  = mode_q;

endmodule
